command_sequencer: RTL and testbench



---
 rtl/command_sequencer.sv | 155 +++++++++++++++
 tb/tb_command_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_sequencer.sv
// command_sequencer: buffers 2-bit commands from an upstream frame register
// in a small FIFO and executes them in order (NOP, PULSE, INC, CLR).
// Optional build macro: CMD_SEQUENCER_EDGE_EN -- accept only on a 0->1
// transition of ready instead of on every cycle ready is high.
module command_sequencer #(
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ready,
  input  logic [1:0]             command,
  output logic                   pulse,
  output logic [CNT_W-1:0]       count,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_IDLE, S_PULSE} state_t;

  state_t           r_state;
  logic [7:0]       r_timer;
  logic             r_pulse;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [1:0]       r_mem [DEPTH];

  state_t           w_state_next;
  logic [7:0]       w_timer_next;
  logic             w_pulse_next;
  logic             w_busy_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_pop;
  logic             w_push;
  logic             w_accept;
  logic             w_full;
  logic             w_empty;
  logic [1:0]       w_head_cmd;

`ifdef CMD_SEQUENCER_EDGE_EN
  logic r_ready_prev;

  // Remember last cycle's ready so only its rising edge is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ready_prev <= 1'b0;
    else     r_ready_prev <= ready;
  end

  assign w_accept = ready & ~r_ready_prev;
`else
  assign w_accept = ready;
`endif

  assign w_full     = (r_level == LW'(DEPTH));
  assign w_empty    = (r_level == '0);
  assign w_head_cmd = r_mem[r_head];
  // A full FIFO still takes a command when the head leaves on the same edge.
  assign w_push     = w_accept & (~w_full | w_pop);

  // FIFO storage: write-only on push; the head is read directly so a pop
  // can execute on the same edge it is taken.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= command;
  end

  // FIFO pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_accept && !w_push) r_overflow <= 1'b1;
    end
  end

  // Executor state register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_pulse <= w_pulse_next;
      r_busy  <= w_busy_next;
      r_count <= w_count_next;
    end
  end

  // Executor next state: pop and run the head in IDLE, count down in PULSE.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_pulse_next = r_pulse;
    w_busy_next  = r_busy;
    w_count_next = r_count;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          case (w_head_cmd)
            2'b01: begin
              w_state_next = S_PULSE;
              w_timer_next = 8'(PULSE_LEN - 1);
              w_pulse_next = 1'b1;
              w_busy_next  = 1'b1;
            end
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b11:   w_count_next = '0;
            default: w_count_next = r_count;
          endcase
        end
      end
      S_PULSE: begin
        if (r_timer == 8'd0) begin
          w_state_next = S_IDLE;
          w_pulse_next = 1'b0;
          w_busy_next  = 1'b0;
        end else begin
          w_timer_next = r_timer - 8'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign pulse    = r_pulse;
  assign busy     = r_busy;
  assign count    = r_count;
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_command_sequencer.sv
// Bench for command_sequencer: directed scenarios plus a randomized run,
// all compared cycle by cycle against a queue-based behavioural model.
module tb_command_sequencer;

  localparam int DEPTH     = 4;
  localparam int PULSE_LEN = 4;
  localparam int CNT_W     = 8;
  localparam int LW        = $clog2(DEPTH) + 1;
  localparam int VW        = 3 + CNT_W + LW;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ready = 1'b0;
  logic [1:0]       command = 2'b00;
  logic             pulse;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic [LW-1:0]    level;
  logic             overflow;

  int total = 0;
  int bad   = 0;

  command_sequencer #(.DEPTH(DEPTH), .PULSE_LEN(PULSE_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ready(ready), .command(command),
    .pulse(pulse), .count(count), .busy(busy), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of pending commands, a count of pulse cycles
  // still to run, the counter and the sticky drop flag.
  logic [1:0] m_q[$];
  int         m_rem;
  int         m_count;
  bit         m_ovf;
  bit         m_prev;

  function automatic void model_reset();
    m_q.delete();
    m_rem = 0; m_count = 0; m_ovf = 0; m_prev = 0;
  endfunction

  function automatic void model_edge(input logic rdy, input logic [1:0] c);
    bit acc;
    bit pop;
    int sz0;
    logic [1:0] h;
`ifdef CMD_SEQUENCER_EDGE_EN
    acc = rdy && !m_prev;
`else
    acc = rdy;
`endif
    sz0 = m_q.size();
    pop = (m_rem == 0) && (sz0 > 0);
    if (pop) begin
      h = m_q.pop_front();
      if (h == 2'b01) m_rem = PULSE_LEN;
      else if (h == 2'b10) m_count = (m_count + 1) % (1 << CNT_W);
      else if (h == 2'b11) m_count = 0;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    if (acc) begin
      if (sz0 < DEPTH || pop) begin
        m_q.push_back(c);
        $display("t=%0t accept cmd=%0d level=%0d", $time, c, m_q.size());
      end else begin
        m_ovf = 1;
        $display("t=%0t drop cmd=%0d", $time, c);
      end
    end
    m_prev = rdy;
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic pb;
    pb = (m_rem > 0);
    return {pb, pb, CNT_W'(m_count), LW'(m_q.size()), m_ovf};
  endfunction

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic step(input logic rdy, input logic [1:0] c);
    ready = rdy;
    command = c;
    @(posedge clk);
    model_edge(rdy, c);
    #1;
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({pulse, busy, count, level, overflow} !== '0) begin
      bad++;
      $display("FAIL reset_init got=%h want=0", {pulse, busy, count, level, overflow});
    end
    reset_release();
    step(1'b1, 2'b10);
    step(1'b1, 2'b01);
    step(1'b0, 2'b00);
    step(1'b0, 2'b00);
    total++;
    if (pulse !== 1'b1 || count !== CNT_W'(1)) begin
      bad++;
      $display("FAIL reset_setup pulse=%b count=%0d want pulse=1 count=1", pulse, count);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({pulse, busy, count, level, overflow} !== '0) begin
      bad++;
      $display("FAIL reset_mid got=%h want=0", {pulse, busy, count, level, overflow});
    end
    reset_release();
  endtask

  task automatic test_inc_clr();
    logic [1:0] cmds [5];
    int seq [5];
    cmds = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
    seq  = '{1, 2, 3, 0, 1};
    for (int k = 0; k < 5; k++) begin
      step(1'b1, cmds[k]);
`ifdef CMD_SEQUENCER_EDGE_EN
      step(1'b0, 2'b00);
      total++;
      if (count !== CNT_W'(seq[k])) begin
        bad++;
        $display("FAIL inc_clr_step%0d count=%0d want=%0d", k, count, seq[k]);
      end
`else
      if (k > 0) begin
        total++;
        if (count !== CNT_W'(seq[k-1])) begin
          bad++;
          $display("FAIL inc_clr_step%0d count=%0d want=%0d", k - 1, count, seq[k-1]);
        end
      end
`endif
      total++;
      if (level > LW'(1) || {pulse, busy, count, level, overflow} !== model_vec()) begin
        bad++;
        $display("FAIL inc_clr_model got=%h want=%h", {pulse, busy, count, level, overflow}, model_vec());
      end
    end
    step(1'b0, 2'b00);
    total++;
    if (count !== CNT_W'(1)) begin
      bad++;
      $display("FAIL inc_clr_final count=%0d want=1", count);
    end
  endtask

  task automatic test_pulse();
    int hi;
    hi = 0;
    step(1'b1, 2'b01);
    total++;
    if (pulse !== 1'b0) begin
      bad++;
      $display("FAIL pulse_accept_edge pulse=%b want=0", pulse);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b00);
      if (pulse === 1'b1 && busy === 1'b1) hi++;
      if (i == 0) begin
        total++;
        if (pulse !== 1'b1 || busy !== 1'b1) begin
          bad++;
          $display("FAIL pulse_start pulse=%b busy=%b want 1 1", pulse, busy);
        end
      end
      total++;
      if ({pulse, busy, count, level, overflow} !== model_vec()) begin
        bad++;
        $display("FAIL pulse_model got=%h want=%h", {pulse, busy, count, level, overflow}, model_vec());
      end
    end
    total++;
    if (hi != PULSE_LEN) begin
      bad++;
      $display("FAIL pulse_len got=%0d want=%0d", hi, PULSE_LEN);
    end
  endtask

  task automatic test_overflow();
    rst = 1'b1;
    #1;
    reset_release();
    step(1'b1, 2'b01);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b10);
`ifndef CMD_SEQUENCER_EDGE_EN
      if (i == 3) begin
        total++;
        if (level !== LW'(4) || overflow !== 1'b0) begin
          bad++;
          $display("FAIL ovf_fill level=%0d ovf=%b want 4 0", level, overflow);
        end
      end
      if (i == 4) begin
        total++;
        if (level !== LW'(4) || overflow !== 1'b1) begin
          bad++;
          $display("FAIL ovf_set level=%0d ovf=%b want 4 1", level, overflow);
        end
      end
`endif
      total++;
      if ({pulse, busy, count, level, overflow} !== model_vec()) begin
        bad++;
        $display("FAIL ovf_model got=%h want=%h", {pulse, busy, count, level, overflow}, model_vec());
      end
    end
    for (int i = 0; i < 10; i++) step(1'b0, 2'b00);
    total++;
    if ({pulse, busy, count, level, overflow} !== model_vec()) begin
      bad++;
      $display("FAIL ovf_drain got=%h want=%h", {pulse, busy, count, level, overflow}, model_vec());
    end
`ifndef CMD_SEQUENCER_EDGE_EN
    total++;
    if (count !== CNT_W'(4) || level !== LW'(0) || overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_end count=%0d level=%0d ovf=%b want 4 0 1", count, level, overflow);
    end
`endif
  endtask

  task automatic test_full_pop();
    rst = 1'b1;
    #1;
    reset_release();
    step(1'b1, 2'b01);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b10);
`ifdef CMD_SEQUENCER_EDGE_EN
      step(1'b0, 2'b00);
`endif
    end
    step(1'b0, 2'b00);
    total++;
    if ({pulse, busy, count, level, overflow} !== model_vec()) begin
      bad++;
      $display("FAIL full_pre got=%h want=%h", {pulse, busy, count, level, overflow}, model_vec());
    end
`ifndef CMD_SEQUENCER_EDGE_EN
    total++;
    if (level !== LW'(4) || busy !== 1'b0) begin
      bad++;
      $display("FAIL full_pre_const level=%0d busy=%b want 4 0", level, busy);
    end
`endif
    step(1'b1, 2'b10);
    total++;
    if ({pulse, busy, count, level, overflow} !== model_vec()) begin
      bad++;
      $display("FAIL full_pop got=%h want=%h", {pulse, busy, count, level, overflow}, model_vec());
    end
`ifndef CMD_SEQUENCER_EDGE_EN
    total++;
    if (level !== LW'(4) || overflow !== 1'b0 || count !== CNT_W'(1)) begin
      bad++;
      $display("FAIL full_pop_const level=%0d ovf=%b count=%0d want 4 0 1", level, overflow, count);
    end
`endif
    for (int i = 0; i < 8; i++) step(1'b0, 2'b00);
    total++;
    if ({pulse, busy, count, level, overflow} !== model_vec()) begin
      bad++;
      $display("FAIL full_drain got=%h want=%h", {pulse, busy, count, level, overflow}, model_vec());
    end
  endtask

  task automatic test_held_ready();
    int want;
`ifdef CMD_SEQUENCER_EDGE_EN
    want = 1;
`else
    want = 3;
`endif
    rst = 1'b1;
    #1;
    reset_release();
    for (int i = 0; i < 3; i++) step(1'b1, 2'b10);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00);
    total++;
    if (count !== CNT_W'(want) || level !== LW'(0)) begin
      bad++;
      $display("FAIL held_ready count=%0d level=%0d want %0d 0", count, level, want);
    end
  endtask

  task automatic test_random();
    logic       r;
    logic [1:0] c;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) < 2) begin
        rst = 1'b1;
        #1;
        total++;
        if ({pulse, busy, count, level, overflow} !== '0) begin
          bad++;
          $display("FAIL rand_reset got=%h want=0", {pulse, busy, count, level, overflow});
        end
        ready = ($urandom_range(1) == 1);
        reset_release();
      end
      r = ($urandom_range(99) < 60);
      c = 2'($urandom_range(3));
      if (c == 2'b01 && $urandom_range(1) == 1) c = 2'b10;
      step(r, c);
      total++;
      if ({pulse, busy, count, level, overflow} !== model_vec()) begin
        bad++;
        $display("FAIL rand_cycle%0d got=%h want=%h", i, {pulse, busy, count, level, overflow}, model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_inc_clr();
    test_pulse();
    test_overflow();
    test_full_pop();
    test_held_ready();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
